// File: rtl/lgdst_ts_txglue_if.sv
// Byte-stream input and serial TS output bundle for the TS transmit glue.
// The source side is the master; the glue itself is the slave.
interface lgdst_ts_txglue_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_sop;
  logic       in_ready;
  logic       ts_clk;
  logic       ts_valid;
  logic       ts_sync;
  logic       ts_d0;

  modport master (
    output in_data, in_valid, in_sop,
    input  in_ready, ts_clk, ts_valid, ts_sync, ts_d0
  );

  modport slave (
    input  in_data, in_valid, in_sop,
    output in_ready, ts_clk, ts_valid, ts_sync, ts_d0
  );
endinterface

// File: rtl/lgdst_ts_txglue.sv
// Serializes MPEG-TS packet bytes onto the serial TS pins with framing and inter-packet gaps.
// Define TS_SYNC_CHECK_EN to drop packets whose sop byte is not SYNC_BYTE.
module lgdst_ts_txglue #(
  parameter int         CLK_DIV   = 2,
  parameter int         PKT_LEN   = 188,
  parameter int         GAP_BITS  = 8,
  parameter logic [7:0] SYNC_BYTE = 8'h47
) (
  input  logic             clk,
  input  logic             reset,
  lgdst_ts_txglue_if.slave bus,
  output logic             pkt_err,
  output logic             busy
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(PKT_LEN);
  localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
`ifdef TS_SYNC_CHECK_EN
    , DROP
`endif
  } state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt;
  logic             bit_tick;
  logic             rdy_en, hold_full, hold_sop, take, accept;
  logic [7:0]       hold_data;
  logic [6:0]       sh, sh_n;
  logic [2:0]       bits_left, bits_n;
  logic [CNT_W-1:0] byte_cnt, cnt_n;
  logic [GAP_W-1:0] gap_cnt, gap_n;
  logic             waiting, wait_n;
  logic             valid_n, sync_n, d0_n, err_n;
  logic             end_pkt, try_start;

  // Free-running divider; a bit tick is the cycle in which ts_clk falls.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      bus.ts_clk <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt    <= '0;
      bus.ts_clk <= ~bus.ts_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign bit_tick = (div_cnt == DIV_LAST) && bus.ts_clk;

  // in_ready also rises while the held byte is being consumed, so the hold refills without a bubble.
  assign bus.in_ready = rdy_en && (!hold_full || take);
  assign accept       = bus.in_valid && bus.in_ready;
  assign busy         = (state != IDLE) || hold_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_en    <= 1'b0;
      hold_full <= 1'b0;
      hold_sop  <= 1'b0;
      hold_data <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        hold_full <= 1'b1;
        hold_sop  <= bus.in_sop;
        hold_data <= bus.in_data;
      end else if (take) begin
        hold_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sh           <= '0;
      bits_left    <= '0;
      byte_cnt     <= '0;
      gap_cnt      <= '0;
      waiting      <= 1'b0;
      bus.ts_valid <= 1'b0;
      bus.ts_sync  <= 1'b0;
      bus.ts_d0    <= 1'b0;
      pkt_err      <= 1'b0;
    end else begin
      state        <= state_n;
      sh           <= sh_n;
      bits_left    <= bits_n;
      byte_cnt     <= cnt_n;
      gap_cnt      <= gap_n;
      waiting      <= wait_n;
      bus.ts_valid <= valid_n;
      bus.ts_sync  <= sync_n;
      bus.ts_d0    <= d0_n;
      pkt_err      <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    sh_n      = sh;
    bits_n    = bits_left;
    cnt_n     = byte_cnt;
    gap_n     = gap_cnt;
    wait_n    = waiting;
    valid_n   = bus.ts_valid;
    sync_n    = bus.ts_sync;
    d0_n      = bus.ts_d0;
    err_n     = 1'b0;
    take      = 1'b0;
    end_pkt   = 1'b0;
    try_start = 1'b0;

    case (state)
      IDLE: try_start = 1'b1;
      SHIFT: begin
        if (bit_tick) begin
          sync_n = 1'b0;
          if (!waiting && bits_left != 3'd0) begin
            d0_n    = sh[6];
            sh_n    = {sh[5:0], 1'b0};
            bits_n  = bits_left - 3'd1;
            valid_n = 1'b1;
          end else if (!waiting && byte_cnt == CNT_LAST) begin
            end_pkt = 1'b1;
          end else if (hold_full && !hold_sop) begin
            take    = 1'b1;
            d0_n    = hold_data[7];
            sh_n    = hold_data[6:0];
            bits_n  = 3'd7;
            cnt_n   = byte_cnt + 1'b1;
            valid_n = 1'b1;
            wait_n  = 1'b0;
          end else if (hold_full) begin
            // A new sop mid-packet truncates; the sop byte stays held for the next packet.
            err_n   = 1'b1;
            end_pkt = 1'b1;
          end else begin
            valid_n = 1'b0;
            wait_n  = 1'b1;
          end
        end
      end
      GAP: begin
        if (bit_tick) begin
          if (gap_cnt == '0) try_start = 1'b1;
          else               gap_n = gap_cnt - 1'b1;
        end
      end
`ifdef TS_SYNC_CHECK_EN
      DROP: begin
        if (hold_full) begin
          if (hold_sop) state_n = IDLE;
          else          take    = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    if (end_pkt) begin
      valid_n = 1'b0;
      sync_n  = 1'b0;
      wait_n  = 1'b0;
      if (GAP_BITS == 0) try_start = 1'b1;
      else begin
        state_n = GAP;
        gap_n   = GAP_LOAD;
      end
    end

    // Gap expiry falls through to idle handling so a waiting sop starts on that same tick.
    if (try_start) begin
      state_n = IDLE;
      if (hold_full && !hold_sop) begin
        take  = 1'b1;
        err_n = 1'b1;
`ifdef TS_SYNC_CHECK_EN
      end else if (hold_full && hold_data != SYNC_BYTE) begin
        take    = 1'b1;
        err_n   = 1'b1;
        state_n = DROP;
`endif
      end else if (hold_full && bit_tick) begin
        take    = 1'b1;
        d0_n    = hold_data[7];
        sh_n    = hold_data[6:0];
        bits_n  = 3'd7;
        cnt_n   = '0;
        valid_n = 1'b1;
        sync_n  = 1'b1;
        state_n = SHIFT;
      end
    end
  end
endmodule
